// File: rtl/avalon_st_fifo.sv
// avalon_st_fifo
//   Avalon-ST FIFO between a producer and a consumer. Carries the packet sideband
//   (sop/eop/empty) with each beat. The sink side hands out credit-style ready with a
//   configurable ready latency. The source side is show-ahead with ready latency 0.
//   A sticky overflow flag records any beat that arrives without a matching grant.
//
// Ports
//   clk_i           clock, all state on the rising edge
//   rst_ni          asynchronous active-low reset
//   snk_data_i      sink data, WIDTH bits
//   snk_valid_i     sink valid
//   snk_sop_i       sink start of packet
//   snk_eop_i       sink end of packet
//   snk_empty_i     empty symbols in the eop beat
//   snk_ready_o     sink ready (credit grant), driven from registers only
//   src_data_o      head entry data
//   src_valid_o     FIFO not empty
//   src_sop_o       head entry sop
//   src_eop_o       head entry eop
//   src_empty_o     head entry empty
//   src_ready_i     consumer ready, latency 0
//   fill_o          number of stored entries
//   almost_full_o   fill_o >= ALMOST_FULL_TH
//   almost_empty_o  fill_o <= ALMOST_EMPTY_TH
//   overflow_o      sticky, set by a beat that arrived without a grant

module avalon_st_fifo #(
    parameter int unsigned DATABITS_PER_SYMBOL = 8,
    parameter int unsigned SYMBOLS_PER_BEAT    = 4,
    parameter int unsigned EMPTY_W             = 2,
    parameter int unsigned DEPTH               = 4,
    parameter int unsigned READY_LATENCY       = 2,
    parameter int unsigned ALMOST_FULL_TH      = 12,
    parameter int unsigned ALMOST_EMPTY_TH     = 2,
    localparam int unsigned WIDTH              = DATABITS_PER_SYMBOL * SYMBOLS_PER_BEAT
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [WIDTH-1:0]   snk_data_i,
    input  logic               snk_valid_i,
    input  logic               snk_sop_i,
    input  logic               snk_eop_i,
    input  logic [EMPTY_W-1:0] snk_empty_i,
    output logic               snk_ready_o,
    output logic [WIDTH-1:0]   src_data_o,
    output logic               src_valid_o,
    output logic               src_sop_o,
    output logic               src_eop_o,
    output logic [EMPTY_W-1:0] src_empty_o,
    input  logic               src_ready_i,
    output logic [DEPTH:0]     fill_o,
    output logic               almost_full_o,
    output logic               almost_empty_o,
    output logic               overflow_o
);

    localparam int unsigned ENTRIES = 2 ** DEPTH;
    localparam int unsigned PW      = DEPTH + 1;
    // Grant history is at least one bit wide so READY_LATENCY=0 still elaborates.
    localparam int unsigned HW      = (READY_LATENCY == 0) ? 1 : READY_LATENCY;
    localparam int unsigned EW      = WIDTH + 2 + EMPTY_W;

    localparam logic [DEPTH:0] ENTRIES_P = PW'(ENTRIES);
    localparam logic [DEPTH:0] RL_P      = PW'(READY_LATENCY);
    localparam logic [DEPTH:0] AF_P      = PW'(ALMOST_FULL_TH);
    localparam logic [DEPTH:0] AE_P      = PW'(ALMOST_EMPTY_TH);

    logic [DEPTH:0]  wr_ptr_q, wr_ptr_d;
    logic [DEPTH:0]  rd_ptr_q, rd_ptr_d;
    logic [DEPTH:0]  fill;
    logic            run_q;
    logic [HW-1:0]   grant_hist_q, grant_hist_d;
    logic            overflow_q, overflow_d;
    logic [EW-1:0]   mem_q [ENTRIES];

    logic            full;
    logic            empty;
    logic            granted;
    logic            push;
    logic            pop;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign fill  = wr_ptr_q - rd_ptr_q;
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[DEPTH-1:0] == rd_ptr_q[DEPTH-1:0]) &&
                   (wr_ptr_q[DEPTH] != rd_ptr_q[DEPTH]);

    // Only grant while there is room for this beat plus every beat still in flight.
    assign snk_ready_o = run_q && ((ENTRIES_P - fill) > RL_P);

    // The grant that covers the current cycle was issued READY_LATENCY cycles ago.
    if (READY_LATENCY == 0) begin : g_rl0
        assign granted = snk_ready_o;
    end else begin : g_rln
        assign granted = grant_hist_q[READY_LATENCY-1];
    end

    always_comb begin
        grant_hist_d    = '0;
        grant_hist_d[0] = snk_ready_o;
        for (int i = 1; i < HW; i++) begin
            grant_hist_d[i] = grant_hist_q[i-1];
        end
    end

    // The full guard never trips while the producer honours grants.
    assign push = snk_valid_i && granted && !full;
    assign pop  = !empty && src_ready_i;

    assign wr_ptr_d   = wr_ptr_q + {{DEPTH{1'b0}}, push};
    assign rd_ptr_d   = rd_ptr_q + {{DEPTH{1'b0}}, pop};
    assign overflow_d = overflow_q || (snk_valid_i && !push);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            run_q        <= 1'b0;
            grant_hist_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            run_q        <= 1'b1;
            grant_hist_q <= grant_hist_d;
            overflow_q   <= overflow_d;
        end
    end

    // Storage has no reset; head fields are don't-care while src_valid_o is low.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q[DEPTH-1:0]] <= {snk_data_i, snk_sop_i, snk_eop_i, snk_empty_i};
        end
    end

    assign {src_data_o, src_sop_o, src_eop_o, src_empty_o} = mem_q[rd_ptr_q[DEPTH-1:0]];
    assign src_valid_o    = !empty;

    assign fill_o         = fill;
    assign almost_full_o  = (fill >= AF_P);
    assign almost_empty_o = (fill <= AE_P);
    assign overflow_o     = overflow_q;

endmodule

// File: tb/tb_avalon_st_fifo.sv
// tb_avalon_st_fifo
//   Directed bench for avalon_st_fifo with default parameters (32-bit beats, 16 entries,
//   sink ready latency 2). Outputs are sampled 1 time unit after each rising edge, and
//   inputs for the following cycle are driven at the same point.

module tb_avalon_st_fifo;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] snk_data_i;
    logic        snk_valid_i;
    logic        snk_sop_i;
    logic        snk_eop_i;
    logic [1:0]  snk_empty_i;
    logic        snk_ready_o;
    logic [31:0] src_data_o;
    logic        src_valid_o;
    logic        src_sop_o;
    logic        src_eop_o;
    logic [1:0]  src_empty_o;
    logic        src_ready_i;
    logic [4:0]  fill_o;
    logic        almost_full_o;
    logic        almost_empty_o;
    logic        overflow_o;

    int checks = 0;
    int errors = 0;

    // Producer-side record of observed ready: g2 is the grant covering the current cycle.
    logic g0 = 1'b0, g1 = 1'b0, g2 = 1'b0;
    logic [31:0] q[$];

    always #5 clk_i = ~clk_i;

    avalon_st_fifo dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .snk_data_i     (snk_data_i),
        .snk_valid_i    (snk_valid_i),
        .snk_sop_i      (snk_sop_i),
        .snk_eop_i      (snk_eop_i),
        .snk_empty_i    (snk_empty_i),
        .snk_ready_o    (snk_ready_o),
        .src_data_o     (src_data_o),
        .src_valid_o    (src_valid_o),
        .src_sop_o      (src_sop_o),
        .src_eop_o      (src_eop_o),
        .src_empty_o    (src_empty_o),
        .src_ready_i    (src_ready_i),
        .fill_o         (fill_o),
        .almost_full_o  (almost_full_o),
        .almost_empty_o (almost_empty_o),
        .overflow_o     (overflow_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        g2 = g1;
        g1 = g0;
        g0 = snk_ready_o;
    endtask

    task automatic clear_grants();
        g0 = 1'b0;
        g1 = 1'b0;
        g2 = 1'b0;
    endtask

    // Compares the DUT against the scoreboard queue, which mirrors the stored entries.
    task automatic model_check();
        check("sb_fill", 32'(fill_o), 32'(q.size()));
        check("sb_valid", 32'(src_valid_o), 32'(q.size() != 0));
        check("sb_almost_full", 32'(almost_full_o), 32'(q.size() >= 12));
        check("sb_almost_empty", 32'(almost_empty_o), 32'(q.size() <= 2));
        if (q.size() != 0) check("sb_data", src_data_o, q[0]);
    endtask

    initial begin
        int sent;
        int rdy_cnt;
        int exp_out;
        logic prev_rdy;
        logic [31:0] pd [3];
        logic        ps [3];
        logic        pe [3];
        logic [1:0]  pm [3];

        rst_ni      = 1'b0;
        snk_data_i  = '0;
        snk_valid_i = 1'b0;
        snk_sop_i   = 1'b0;
        snk_eop_i   = 1'b0;
        snk_empty_i = '0;
        src_ready_i = 1'b0;

        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_fill", 32'(fill_o), 0);
        check("rst_src_valid", 32'(src_valid_o), 0);
        check("rst_snk_ready", 32'(snk_ready_o), 0);
        check("rst_almost_empty", 32'(almost_empty_o), 1);
        check("rst_almost_full", 32'(almost_full_o), 0);
        check("rst_overflow", 32'(overflow_o), 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        check("release_ready_low", 32'(snk_ready_o), 0);
        clear_grants();

        // Burst into a stalled consumer: 16 grants, 16 beats, ready falls at fill 14
        sent     = 0;
        rdy_cnt  = 0;
        prev_rdy = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (snk_ready_o) rdy_cnt++;
            if (prev_rdy && !snk_ready_o) check("burst_ready_fall_fill", 32'(fill_o), 14);
            prev_rdy = snk_ready_o;
            if (g2 && sent < 32) begin
                snk_valid_i = 1'b1;
                snk_data_i  = 32'(sent);
                sent++;
            end else begin
                snk_valid_i = 1'b0;
            end
        end
        snk_valid_i = 1'b0;
        check("burst_sent", 32'(sent), 16);
        check("burst_ready_cycles", 32'(rdy_cnt), 16);
        check("burst_fill", 32'(fill_o), 16);
        check("burst_ready", 32'(snk_ready_o), 0);
        check("burst_almost_full", 32'(almost_full_o), 1);
        check("burst_almost_empty", 32'(almost_empty_o), 0);
        check("burst_overflow", 32'(overflow_o), 0);

        // Drain in order
        src_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("drain_valid", 32'(src_valid_o), 1);
            check("drain_data", src_data_o, 32'(i));
            tick();
        end
        check("drain_empty_valid", 32'(src_valid_o), 0);
        check("drain_empty_fill", 32'(fill_o), 0);
        check("drain_almost_empty", 32'(almost_empty_o), 1);
        repeat (3) tick();
        check("pop_when_empty_fill", 32'(fill_o), 0);
        check("pop_when_empty_valid", 32'(src_valid_o), 0);

        // Streaming: one beat in and one out per cycle, fill steady at 1
        sent    = 0;
        exp_out = 0;
        for (int k = 0; k < 24; k++) begin
            if (k >= 2) begin
                check("stream_valid", 32'(src_valid_o), 1);
                check("stream_fill", 32'(fill_o), 1);
            end
            if (src_valid_o) begin
                check("stream_data", src_data_o, 32'h100 + 32'(exp_out));
                exp_out++;
            end
            if (g2) begin
                snk_valid_i = 1'b1;
                snk_data_i  = 32'h100 + 32'(sent);
                sent++;
            end else begin
                snk_valid_i = 1'b0;
            end
            tick();
        end
        snk_valid_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (src_valid_o) begin
                check("stream_tail_data", src_data_o, 32'h100 + 32'(exp_out));
                exp_out++;
            end
            tick();
        end
        check("stream_count", 32'(exp_out), 32'(sent));
        check("stream_sent", 32'(sent), 24);
        check("stream_end_fill", 32'(fill_o), 0);

        // Reset mid-stream with 5 entries stored
        src_ready_i = 1'b0;
        sent        = 0;
        for (int k = 0; k < 12; k++) begin
            if (g2 && sent < 5) begin
                snk_valid_i = 1'b1;
                snk_data_i  = 32'h200 + 32'(sent);
                sent++;
            end else begin
                snk_valid_i = 1'b0;
            end
            tick();
        end
        check("pre_rst_fill", 32'(fill_o), 5);
        check("pre_rst_head", src_data_o, 32'h200);
        #2;
        rst_ni = 1'b0;
        #1;
        check("mid_rst_fill", 32'(fill_o), 0);
        check("mid_rst_valid", 32'(src_valid_o), 0);
        check("mid_rst_ready", 32'(snk_ready_o), 0);
        check("mid_rst_almost_empty", 32'(almost_empty_o), 1);
        check("mid_rst_almost_full", 32'(almost_full_o), 0);
        repeat (3) tick();
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        check("mid_release_ready_low", 32'(snk_ready_o), 0);
        clear_grants();

        // Unsolicited beats in cycles 1 and 2 after release, both covered by ready=0
        tick();
        snk_valid_i = 1'b1;
        snk_data_i  = 32'hBAD1;
        tick();
        check("ready_two_edges_after_release", 32'(snk_ready_o), 1);
        snk_data_i  = 32'hBAD2;
        tick();
        snk_valid_i = 1'b0;
        check("ovf_flag", 32'(overflow_o), 1);
        check("ovf_fill", 32'(fill_o), 0);
        check("ovf_valid", 32'(src_valid_o), 0);
        repeat (4) tick();
        check("ovf_sticky", 32'(overflow_o), 1);
        check("ovf_sticky_fill", 32'(fill_o), 0);

        // Only reset clears overflow
        #2;
        rst_ni = 1'b0;
        #1;
        check("ovf_cleared_by_reset", 32'(overflow_o), 0);
        repeat (2) tick();
        @(negedge clk_i);
        rst_ni = 1'b1;
        clear_grants();
        repeat (4) tick();

        // 3-beat packet: sideband returned unmodified
        pd[0] = 32'h300; ps[0] = 1'b1; pe[0] = 1'b0; pm[0] = 2'd0;
        pd[1] = 32'h301; ps[1] = 1'b0; pe[1] = 1'b0; pm[1] = 2'd0;
        pd[2] = 32'h302; ps[2] = 1'b0; pe[2] = 1'b1; pm[2] = 2'd2;
        sent = 0;
        for (int k = 0; k < 8; k++) begin
            if (g2 && sent < 3) begin
                snk_valid_i = 1'b1;
                snk_data_i  = pd[sent];
                snk_sop_i   = ps[sent];
                snk_eop_i   = pe[sent];
                snk_empty_i = pm[sent];
                sent++;
            end else begin
                snk_valid_i = 1'b0;
                snk_sop_i   = 1'b0;
                snk_eop_i   = 1'b0;
                snk_empty_i = '0;
            end
            tick();
        end
        check("pkt_fill", 32'(fill_o), 3);
        for (int i = 0; i < 3; i++) begin
            check("pkt_data", src_data_o, pd[i]);
            check("pkt_sop", 32'(src_sop_o), 32'(ps[i]));
            check("pkt_eop", 32'(src_eop_o), 32'(pe[i]));
            check("pkt_empty", 32'(src_empty_o), 32'(pm[i]));
            src_ready_i = 1'b1;
            tick();
        end
        src_ready_i = 1'b0;
        check("pkt_drained", 32'(fill_o), 0);
        check("pkt_overflow", 32'(overflow_o), 0);

        // Pointer wrap: random consumer against a scoreboard, then drain
        sent = 0;
        for (int k = 0; k < 40; k++) begin
            model_check();
            src_ready_i = ($urandom_range(3, 0) == 0);
            if (src_ready_i && q.size() != 0) void'(q.pop_front());
            if (g2) begin
                snk_valid_i = 1'b1;
                snk_data_i  = 32'h400 + 32'(sent);
                q.push_back(32'h400 + 32'(sent));
                sent++;
            end else begin
                snk_valid_i = 1'b0;
            end
            tick();
        end
        snk_valid_i = 1'b0;
        src_ready_i = 1'b1;
        for (int k = 0; k < 20; k++) begin
            model_check();
            if (q.size() != 0) void'(q.pop_front());
            tick();
        end
        model_check();
        check("wrap_overflow", 32'(overflow_o), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
